tlb_ctrl: RTL and testbench
===========================

TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 SHALL have parameter ENTRIES, default 32, number of TLB entries.
REQ-002 SHALL have parameter IDXBITS, default 5, index width (log2 ENTRIES).
REQ-003 SHALL have ports: clk  in  1  clock; resetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: req_valid  in  1  TLB instruction request; req_op  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR; req_ready  out  1  request accepted when high with req_valid.
REQ-005 SHALL have ports: index_in  in  IDXBITS  CP0 Index; wired_in  in  IDXBITS  CP0 Wired; wired_we  in  1  CP0 Wired written this cycle.
REQ-006 SHALL have ports: tlb_write  out  1  TLB entry write; tlb_idx  out  IDXBITS  TLB entry index.
REQ-007 SHALL have ports: probe_index  in  32  TLB probe result; read_hi, read_lo0, read_lo1  in  32  TLB read data; read_mask  in  12  TLB read PageMask.
REQ-008 SHALL have ports: cp0_index_we  out  1; cp0_index_data  out  32; cp0_entry_we  out  1  load EntryHi/Lo0/Lo1/PageMask; cp0_hi, cp0_lo0, cp0_lo1  out  32; cp0_mask  out  12.
REQ-009 SHALL have ports: random_out  out  IDXBITS  CP0 Random; resp_valid  out  1  operation complete; tlb_flush  out  1  translation state changed.

Function
REQ-010 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; req_ready = (state==IDLE).
REQ-011 SHALL, on accept, latch req_op and the target index: index_in for TLBP/TLBR/TLBWI, current random_out for TLBWR.
REQ-012 SHALL drive tlb_idx from the latched index in EXEC and DONE; 0 in IDLE.
REQ-013 SHALL assert tlb_write for exactly the EXEC cycle of TLBWI/TLBWR; never otherwise.
REQ-014 SHALL, at the end of EXEC, register probe_index (TLBP) or read_hi/lo0/lo1/mask (TLBR).
REQ-015 SHALL, in DONE, pulse resp_valid for one cycle for every op; cp0_index_we only for TLBP; cp0_entry_we only for TLBR; tlb_flush only for TLBWI/TLBWR.
REQ-016 SHALL give fixed latency: accept in cycle N, resp_valid in cycle N+2, next accept no earlier than N+3.
REQ-017 SHALL hold cp0_* data outputs stable from DONE until the next DONE.
REQ-018 SHALL decrement random_out by 1 each cycle; when random_out==wired_in or random_out==0, next value is ENTRIES-1.
REQ-019 SHALL set random_out to ENTRIES-1 in the cycle after wired_we, overriding decrement.
REQ-020 SHALL hold random_out at ENTRIES-1 while wired_in >= ENTRIES-1.
REQ-021 SHALL ignore req_valid outside IDLE; request fields need only be valid in the accept cycle.
REQ-022 SHALL require the requester to hold CP0 EntryHi/EntryLo/PageMask stable from accept through DONE.

Reset
REQ-023 SHALL, on resetn low, go to IDLE, random_out=ENTRIES-1, all other outputs 0, latched data 0.
REQ-024 SHALL abort any in-flight op on reset: no tlb_write, resp_valid or CP0 pulse afterwards.

Configuration
REQ-025 SHALL, with TLB_CTRL_RANDOM_EN defined, implement REQ-018..020 and TLBWR as in REQ-011.
REQ-026 SHALL, without TLB_CTRL_RANDOM_EN, tie random_out to ENTRIES-1, ignore wired_in/wired_we, and execute TLBWR identically to TLBWI.

Structure
REQ-027 SHALL place op encodings (TLBP/TLBR/TLBWI/TLBWR) and FSM state encodings in the shared package; ENTRIES/IDXBITS defaults come from the existing TLB constants.
REQ-028 SHALL implement the Random counter as sub-module tlb_random.

Verification
REQ-029 TLBWI, index_in=5 -> tlb_write high one cycle with tlb_idx=5 at N+1, tlb_flush and resp_valid at N+2, no CP0 pulses.
REQ-030 TLBP with probe_index=32'h8000_0000 -> cp0_index_we at N+2, cp0_index_data=32'h8000_0000; with probe_index=3 -> data 3.
REQ-031 TLBR, index_in=7, read_hi=32'h1234_5000 -> cp0_entry_we at N+2, cp0_hi=32'h1234_5000, tlb_idx=7.
REQ-032 wired_in=4, ENTRIES=32 -> random_out sequence 31..4 then 31; wired_we pulse mid-sequence -> 31 next cycle; TLBWR at random 20 -> write at idx 20.
REQ-033 Back-to-back req_valid high -> accepts every 3 cycles only; resetn low during EXEC of TLBWI -> no tlb_write, no resp_valid, random_out=31.
REQ-034 Build without TLB_CTRL_RANDOM_EN -> random_out constant 31; TLBWR, index_in=2 -> write at idx 2.

Source files
------------

// File: rtl/tlb_ctrl_pkg.sv
// Shared TLB controller definitions: TLB geometry, instruction opcodes and
// controller FSM state encodings.
package tlb_ctrl_pkg;

  // Existing TLB geometry constants
  localparam int TLB_ENTRIES = 32;
  localparam int TLB_IDXBITS = 5;

  // TLB instruction opcodes as presented on req_op
  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  // Controller FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Both write opcodes share the MSB; this keeps the decode in one place
  function automatic logic op_is_write(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/tlb_random.sv
// CP0 Random counter: counts down from ENTRIES-1 to Wired (or 0) and wraps
// back to ENTRIES-1. A Wired write, or a Wired value that leaves no
// replaceable entries, forces the counter to ENTRIES-1.
module tlb_random
  import tlb_ctrl_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  parameter int IDXBITS = TLB_IDXBITS
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [IDXBITS-1:0] i_wired,
  input  logic               i_wired_we,
  output logic [IDXBITS-1:0] o_random
);

  localparam logic [IDXBITS-1:0] MAX_IDX = IDXBITS'(ENTRIES - 1);

  logic [IDXBITS-1:0] r_random;
  logic [IDXBITS-1:0] w_random_nxt;

  // Next Random value: reload on Wired write, saturated Wired or wrap point
  always_comb begin
    w_random_nxt = r_random;
    if (i_wired_we || (i_wired >= MAX_IDX) ||
        (r_random == i_wired) || (r_random == {IDXBITS{1'b0}})) begin
      w_random_nxt = MAX_IDX;
    end else begin
      w_random_nxt = r_random - {{(IDXBITS-1){1'b0}}, 1'b1};
    end
  end

  // Random register with synchronous reset to the top entry
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_random <= MAX_IDX;
    end else begin
      r_random <= w_random_nxt;
    end
  end

  assign o_random = r_random;

endmodule

// File: rtl/tlb_ctrl.sv
// TLB instruction controller (TLBP/TLBR/TLBWI/TLBWR) sequencing the TLB array
// and CP0 register updates with a fixed IDLE -> EXEC -> DONE cadence.
// Optional feature macro: TLB_CTRL_RANDOM_EN enables the CP0 Random counter
// and random-index TLBWR; without it Random is tied to ENTRIES-1 and TLBWR
// behaves as TLBWI.
module tlb_ctrl
  import tlb_ctrl_pkg::*;
#(
  parameter int ENTRIES = TLB_ENTRIES,
  parameter int IDXBITS = TLB_IDXBITS
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  input  logic [1:0]         req_op,
  output logic               req_ready,
  input  logic [IDXBITS-1:0] index_in,
  input  logic [IDXBITS-1:0] wired_in,
  input  logic               wired_we,
  output logic               tlb_write,
  output logic [IDXBITS-1:0] tlb_idx,
  input  logic [31:0]        probe_index,
  input  logic [31:0]        read_hi,
  input  logic [31:0]        read_lo0,
  input  logic [31:0]        read_lo1,
  input  logic [11:0]        read_mask,
  output logic               cp0_index_we,
  output logic [31:0]        cp0_index_data,
  output logic               cp0_entry_we,
  output logic [31:0]        cp0_hi,
  output logic [31:0]        cp0_lo0,
  output logic [31:0]        cp0_lo1,
  output logic [11:0]        cp0_mask,
  output logic [IDXBITS-1:0] random_out,
  output logic               resp_valid,
  output logic               tlb_flush
);

  logic [1:0]         r_state;
  logic [1:0]         r_op;
  logic [IDXBITS-1:0] r_idx;
  logic               r_tlb_write;
  logic               r_resp_valid;
  logic               r_index_we;
  logic               r_entry_we;
  logic               r_flush;
  logic [31:0]        r_index_data;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo0;
  logic [31:0]        r_lo1;
  logic [11:0]        r_mask;

  logic [IDXBITS-1:0] w_random;
  logic [IDXBITS-1:0] w_target;

`ifdef TLB_CTRL_RANDOM_EN
  tlb_random #(
    .ENTRIES (ENTRIES),
    .IDXBITS (IDXBITS)
  ) u_random (
    .clk        (clk),
    .resetn     (resetn),
    .i_wired    (wired_in),
    .i_wired_we (wired_we),
    .o_random   (w_random)
  );

  // TLBWR targets the current Random value, everything else uses Index
  always_comb begin
    w_target = index_in;
    if (req_op == OP_TLBWR) begin
      w_target = w_random;
    end else begin
      w_target = index_in;
    end
  end
`else
  // Wired has no effect when Random is fixed at the top entry
  logic w_unused_wired;
  assign w_unused_wired = ^{wired_in, wired_we};
  assign w_random       = IDXBITS'(ENTRIES - 1);

  // Without Random, TLBWR is executed exactly like TLBWI
  always_comb begin
    w_target = index_in;
  end
`endif

  // Controller FSM: latch request on accept, drive TLB in EXEC, report in DONE
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_TLBP;
      r_idx        <= {IDXBITS{1'b0}};
      r_tlb_write  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_index_we   <= 1'b0;
      r_entry_we   <= 1'b0;
      r_flush      <= 1'b0;
      r_index_data <= 32'h0000_0000;
      r_hi         <= 32'h0000_0000;
      r_lo0        <= 32'h0000_0000;
      r_lo1        <= 32'h0000_0000;
      r_mask       <= 12'h000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_state     <= ST_EXEC;
            r_op        <= req_op;
            r_idx       <= w_target;
            r_tlb_write <= op_is_write(req_op);
          end
        end
        ST_EXEC: begin
          r_state      <= ST_DONE;
          r_tlb_write  <= 1'b0;
          r_resp_valid <= 1'b1;
          r_index_we   <= (r_op == OP_TLBP);
          r_entry_we   <= (r_op == OP_TLBR);
          r_flush      <= op_is_write(r_op);
          case (r_op)
            OP_TLBP: begin
              r_index_data <= probe_index;
            end
            OP_TLBR: begin
              r_hi   <= read_hi;
              r_lo0  <= read_lo0;
              r_lo1  <= read_lo1;
              r_mask <= read_mask;
            end
            default: begin
              r_index_data <= r_index_data;
            end
          endcase
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_idx        <= {IDXBITS{1'b0}};
          r_resp_valid <= 1'b0;
          r_index_we   <= 1'b0;
          r_entry_we   <= 1'b0;
          r_flush      <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_idx        <= {IDXBITS{1'b0}};
          r_tlb_write  <= 1'b0;
          r_resp_valid <= 1'b0;
          r_index_we   <= 1'b0;
          r_entry_we   <= 1'b0;
          r_flush      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = (r_state == ST_IDLE);
  // A reset arriving during EXEC suppresses the write in that same cycle
  assign tlb_write      = r_tlb_write & resetn;
  assign tlb_idx        = r_idx;
  assign resp_valid     = r_resp_valid;
  assign cp0_index_we   = r_index_we;
  assign cp0_entry_we   = r_entry_we;
  assign tlb_flush      = r_flush;
  assign cp0_index_data = r_index_data;
  assign cp0_hi         = r_hi;
  assign cp0_lo0        = r_lo0;
  assign cp0_lo1        = r_lo1;
  assign cp0_mask       = r_mask;
  assign random_out     = w_random;

endmodule

// File: tb/tb_tlb_ctrl.sv
// Self-checking bench for tlb_ctrl: directed scenarios plus randomized
// traffic, all compared against a cycle-count based reference model.
module tb_tlb_ctrl;

  localparam int ENT = 32;
  localparam int IB  = 5;
  localparam logic [IB-1:0] TOP = 5'd31;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid;
  logic [1:0]    req_op;
  logic          req_ready;
  logic [IB-1:0] index_in;
  logic [IB-1:0] wired_in;
  logic          wired_we;
  logic          tlb_write;
  logic [IB-1:0] tlb_idx;
  logic [31:0]   probe_index, read_hi, read_lo0, read_lo1;
  logic [11:0]   read_mask;
  logic          cp0_index_we, cp0_entry_we, resp_valid, tlb_flush;
  logic [31:0]   cp0_index_data, cp0_hi, cp0_lo0, cp0_lo1;
  logic [11:0]   cp0_mask;
  logic [IB-1:0] random_out;

  always #5 clk = ~clk;

  tlb_ctrl #(.ENTRIES(ENT), .IDXBITS(IB)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
    .req_ready(req_ready), .index_in(index_in), .wired_in(wired_in),
    .wired_we(wired_we), .tlb_write(tlb_write), .tlb_idx(tlb_idx),
    .probe_index(probe_index), .read_hi(read_hi), .read_lo0(read_lo0),
    .read_lo1(read_lo1), .read_mask(read_mask), .cp0_index_we(cp0_index_we),
    .cp0_index_data(cp0_index_data), .cp0_entry_we(cp0_entry_we),
    .cp0_hi(cp0_hi), .cp0_lo0(cp0_lo0), .cp0_lo1(cp0_lo1),
    .cp0_mask(cp0_mask), .random_out(random_out), .resp_valid(resp_valid),
    .tlb_flush(tlb_flush)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: an op accepted in cycle A writes in A+1, reports in A+2,
  // and the controller is free again from A+3.
  int            cyc = 0;
  int            acc = -100;
  logic [1:0]    m_op  = 2'b00;
  logic [IB-1:0] m_idx = '0;
  logic [IB-1:0] m_rand = TOP;
  logic [31:0]   m_cidx = '0, m_hi = '0, m_lo0 = '0, m_lo1 = '0;
  logic [11:0]   m_mask = '0;

  // Check the current cycle against the model, advance the model, then clock
  task automatic step();
    int ph;
    logic busy;
    logic [IB-1:0] nrand;
    ph   = cyc - acc;
    busy = (ph == 1) || (ph == 2);
    #1;
    chk("req_ready",  32'(req_ready),    32'(!busy));
    chk("tlb_write",  32'(tlb_write),    32'(ph == 1 && m_op[1] && resetn));
    chk("tlb_idx",    32'(tlb_idx),      busy ? 32'(m_idx) : 32'd0);
    chk("resp_valid", 32'(resp_valid),   32'(ph == 2));
    chk("index_we",   32'(cp0_index_we), 32'(ph == 2 && m_op == 2'b00));
    chk("entry_we",   32'(cp0_entry_we), 32'(ph == 2 && m_op == 2'b01));
    chk("tlb_flush",  32'(tlb_flush),    32'(ph == 2 && m_op[1]));
    chk("random_out", 32'(random_out),   32'(m_rand));
    chk("index_data", cp0_index_data,    m_cidx);
    chk("cp0_hi",     cp0_hi,            m_hi);
    chk("cp0_lo0",    cp0_lo0,           m_lo0);
    chk("cp0_lo1",    cp0_lo1,           m_lo1);
    chk("cp0_mask",   32'(cp0_mask),     32'(m_mask));
    if (!resetn) begin
      acc = -100; m_op = 2'b00; m_idx = '0; m_rand = TOP;
      m_cidx = '0; m_hi = '0; m_lo0 = '0; m_lo1 = '0; m_mask = '0;
    end else begin
      if (ph == 1 && m_op == 2'b00) m_cidx = probe_index;
      if (ph == 1 && m_op == 2'b01) begin
        m_hi = read_hi; m_lo0 = read_lo0; m_lo1 = read_lo1; m_mask = read_mask;
      end
`ifdef TLB_CTRL_RANDOM_EN
      if (wired_we || int'(wired_in) >= ENT - 1 || m_rand == wired_in || m_rand == 0)
        nrand = TOP;
      else
        nrand = IB'(int'(m_rand) - 1);
`else
      nrand = TOP;
`endif
      if (!busy && req_valid) begin
        acc  = cyc;
        m_op = req_op;
`ifdef TLB_CTRL_RANDOM_EN
        m_idx = (req_op == 2'b11) ? m_rand : index_in;
`else
        m_idx = index_in;
`endif
      end
      m_rand = nrand;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    resetn = 1'b1; req_valid = 1'b0; req_op = 2'b00; index_in = '0;
    wired_we = 1'b0; probe_index = '0; read_hi = '0; read_lo0 = '0;
    read_lo1 = '0; read_mask = '0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [IB-1:0] idx);
    req_valid = 1'b1; req_op = op; index_in = idx;
    step();
    req_valid = 1'b0; req_op = 2'($urandom); index_in = IB'($urandom);
  endtask

  task automatic rnd_inputs();
    resetn      = ($urandom_range(0, 63) != 0);
    req_valid   = 1'($urandom);
    req_op      = 2'($urandom);
    index_in    = IB'($urandom);
    wired_we    = ($urandom_range(0, 15) == 0);
    if (wired_we) wired_in = ($urandom_range(0, 7) == 0) ? TOP : IB'($urandom_range(0, 12));
    probe_index = $urandom;
    read_hi     = $urandom;
    read_lo0    = $urandom;
    read_lo1    = $urandom;
    read_mask   = 12'($urandom);
  endtask

  initial begin
    int guard;
    idle_inputs();
    wired_in = 5'd4;
    resetn   = 1'b0;
    @(posedge clk);
    #1;
    step();
    resetn = 1'b1;
    step();

    // TLBWI to entry 5
    issue(2'b10, 5'd5);
    repeat (3) step();

    // TLBP with sign-bit probe miss, then a hit at index 3
    probe_index = 32'h8000_0000;
    issue(2'b00, 5'd1);
    repeat (3) step();
    chk("tlbp_miss", cp0_index_data, 32'h8000_0000);
    probe_index = 32'd3;
    issue(2'b00, 5'd1);
    repeat (3) step();
    chk("tlbp_hit", cp0_index_data, 32'd3);

    // TLBR of entry 7
    read_hi = 32'h1234_5000; read_lo0 = 32'h0000_1111; read_lo1 = 32'h0000_2222;
    read_mask = 12'h0ff;
    issue(2'b01, 5'd7);
    repeat (3) step();
    chk("tlbr_hi", cp0_hi, 32'h1234_5000);

    // Random walk with Wired=4, reloaded mid-sequence by a Wired write
    wired_in = 5'd4; wired_we = 1'b1;
    step();
    wired_we = 1'b0;
    repeat (40) step();
    repeat (5) step();
    wired_we = 1'b1;
    step();
    wired_we = 1'b0;
    step();

    // TLBWR once Random reaches 20 (entry 2 when Random is disabled)
    guard = 0;
`ifdef TLB_CTRL_RANDOM_EN
    while (m_rand != 5'd20 && guard < 64) begin
      step();
      guard++;
    end
    chk("rand_reach20", 32'(m_rand), 32'd20);
    issue(2'b11, 5'd2);
    chk("tlbwr_idx", 32'(tlb_idx), 32'd20);
`else
    issue(2'b11, 5'd2);
    chk("tlbwr_idx", 32'(tlb_idx), 32'd2);
`endif
    repeat (3) step();

    // Back-to-back requests: only one accept every three cycles
    req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req_op = 2'($urandom); index_in = IB'($urandom);
      step();
    end
    req_valid = 1'b0;
    repeat (3) step();

    // Reset during EXEC of a TLBWI aborts it
    issue(2'b10, 5'd9);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("abort_rand", 32'(random_out), 32'd31);
    repeat (4) step();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rnd_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
